// File: rtl/i2s_tx.sv
// I2S master transmitter: 64-BCLK stereo frames, 32-bit MSB-first slots, one-bit data delay.
// Both serial clocks derive from ACLK; a one-entry holding buffer decouples the PCM handshake.
module i2s_tx #(
    parameter int BCLK_DIV = 8,
    parameter int DATA_W   = 24
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic              ENABLE,
    input  logic [DATA_W-1:0] DIN_L,
    input  logic [DATA_W-1:0] DIN_R,
    input  logic              DIN_VALID,
    output logic              DIN_READY,
    output logic              BCLK,
    output logic              LRCLK,
    output logic              DOUT,
    output logic              UNDERRUN
);

    localparam int DCNT_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DCNT_W-1:0] DCNT_MAX  = DCNT_W'(BCLK_DIV - 1);
    localparam logic [DCNT_W-1:0] DCNT_HALF = DCNT_W'(BCLK_DIV / 2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [5:0]          bcnt_q, bcnt_d;
    logic [63:0]         shift_q, shift_d;
    logic                lrclk_q, lrclk_d;
    logic                bclk_q, bclk_d;
    logic                underrun_q, underrun_d;
    logic                ready_q, ready_d;
    logic                bufFull_q, bufFull_d;
    logic [DATA_W-1:0]   bufL_q, bufL_d;
    logic [DATA_W-1:0]   bufR_q, bufR_d;

    logic                fallEvt;
    logic                frameWrap;
    logic                stopNow;
    logic                doLoad;
    logic                handshake;
    logic [31:0]         slotL;
    logic [31:0]         slotR;

    // Samples sit at the top of each slot with the unused LSBs zero.
    assign slotL = 32'(bufL_q) << (32 - DATA_W);
    assign slotR = 32'(bufR_q) << (32 - DATA_W);

    assign handshake = DIN_VALID && ready_q;
    assign fallEvt   = (state_q != IDLE) && (dcnt_q == DCNT_MAX);
    assign frameWrap = fallEvt && (bcnt_q == 6'd63);
    assign stopNow   = frameWrap && (state_q == DRAIN) && !ENABLE;
    assign doLoad    = frameWrap && !stopNow;

    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        bcnt_d     = bcnt_q;
        shift_d    = shift_q;
        lrclk_d    = lrclk_q;
        underrun_d = 1'b0;
        bufFull_d  = bufFull_q;
        bufL_d     = bufL_q;
        bufR_d     = bufR_q;

        case (state_q)
            IDLE: begin
                dcnt_d = '0;
                if (ENABLE) begin
                    state_d = RUN;
                    bcnt_d  = 6'd63;
                end
            end
            RUN: begin
                if (!ENABLE) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ENABLE) begin
                    state_d = RUN;
                end else if (stopNow) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            dcnt_d = fallEvt ? '0 : dcnt_q + DCNT_W'(1);
        end

        // Everything visible on the serial side moves only with a BCLK falling edge.
        if (fallEvt) begin
            bcnt_d  = bcnt_q + 6'd1;
            lrclk_d = (bcnt_d >= 6'd31) && (bcnt_d <= 6'd62);
            shift_d = {shift_q[62:0], 1'b0};
            if (doLoad) begin
                shift_d    = bufFull_q ? {slotL, slotR} : 64'd0;
                underrun_d = !bufFull_q;
                bufFull_d  = 1'b0;
            end
            if (stopNow) begin
                shift_d = 64'd0;
            end
        end

        if (handshake) begin
            bufFull_d = 1'b1;
            bufL_d    = DIN_L;
            bufR_d    = DIN_R;
        end
    end

    assign bclk_d  = (dcnt_d >= DCNT_HALF);
    assign ready_d = !bufFull_d;

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state_q    <= IDLE;
            dcnt_q     <= '0;
            bcnt_q     <= '0;
            shift_q    <= '0;
            lrclk_q    <= 1'b0;
            bclk_q     <= 1'b0;
            underrun_q <= 1'b0;
            ready_q    <= 1'b0;
            bufFull_q  <= 1'b0;
            bufL_q     <= '0;
            bufR_q     <= '0;
        end else begin
            state_q    <= state_d;
            dcnt_q     <= dcnt_d;
            bcnt_q     <= bcnt_d;
            shift_q    <= shift_d;
            lrclk_q    <= lrclk_d;
            bclk_q     <= bclk_d;
            underrun_q <= underrun_d;
            ready_q    <= ready_d;
            bufFull_q  <= bufFull_d;
            bufL_q     <= bufL_d;
            bufR_q     <= bufR_d;
        end
    end

    assign BCLK      = bclk_q;
    assign LRCLK     = lrclk_q;
    assign DOUT      = shift_q[63];
    assign UNDERRUN  = underrun_q;
    assign DIN_READY = ready_q;

endmodule
